// File: rtl/imem_boot_loader.sv
// Streams a program into the 128x32 instruction memory, pads the rest with FILL_WORD, then releases the CPU.
// Latency: the write port is registered (word appears the cycle after its transfer); cpu_run rises one cycle after the final write.
// Backpressure: load_ready is high only in LOAD and depends on state alone; gaps in load_valid simply stall the load.
//
// Ports:
//   clk, reset (async, active-low)   clock / reset
//   start                            pulse: begin a (re)load from IDLE, RUN or ERROR
//   load_valid/load_ready            word handshake; load_data + load_last qualified by it
//   mem_we/mem_waddr/mem_wdata       registered instruction-memory write port
//   cpu_run, busy, overflow          status; overflow is held until the next start
//   word_count                       words accepted in the current/last load (0..DEPTH)
module imem_boot_loader #(
    parameter int            DEPTH     = 128,
    parameter int            AW        = 7,
    parameter int            DW        = 32,
    parameter logic [DW-1:0] FILL_WORD = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_run,
    output logic          busy,
    output logic          overflow,
    output logic [AW:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   MAX_COUNT = (AW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          run_q, run_d;

    logic xfer;
    logic at_end;

    // load_ready is decoded from state only, so the transfer never loops back through load_valid.
    assign xfer   = (state_q == S_LOAD) && load_valid;
    assign at_end = (ptr_q == LAST_ADDR);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD: begin
                // start is deliberately not looked at here: a reload cannot interrupt a load.
                if (xfer) begin
                    if (load_last)   state_d = at_end ? S_RUN : S_FILL;
                    else if (at_end) state_d = S_ERROR;
                end
            end
            S_FILL:  if (at_end) state_d = S_RUN;
            S_RUN:   if (start) state_d = S_LOAD;
            S_ERROR: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        load_ready = (state_q == S_LOAD);
        busy       = (state_q == S_LOAD) || (state_q == S_FILL);
        overflow   = (state_q == S_ERROR);
        // The state reaches RUN in the same cycle the final write is on the port; registering
        // "in RUN and staying there" delays cpu_run by one cycle and drops it the cycle after start.
        run_d      = (state_q == S_RUN) && (state_d == S_RUN);
    end

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    ptr_d = '0;
                    cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q;
                    wdata_d = load_data;
                    ptr_d   = ptr_q + AW'(1);
                    if (cnt_q != MAX_COUNT) cnt_d = cnt_q + (AW + 1)'(1);
                end
            end
            S_FILL: begin
                we_d    = 1'b1;
                waddr_d = ptr_q;
                wdata_d = FILL_WORD;
                ptr_d   = ptr_q + AW'(1);
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_run    = run_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int          DEPTH = 128;
    localparam logic [31:0] FILL  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready, mem_we, cpu_run, busy, overflow;
    logic [6:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  word_count;

    imem_boot_loader dut (
        .clk(clk), .reset(reset_n), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .overflow(overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: every observed write with the cycle it was seen in.
    logic [6:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          run_rise = -1;
    logic        run_prev = 1'b0;
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_waddr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
        if (cpu_run && !run_prev) run_rise = cyc;
        run_prev = cpu_run;
    end

    // Reference: what the loader was handed, and where the log of the current load begins.
    logic [31:0] sent_q[$];
    int          xfer_q[$];
    int          base;
    bit          tmo;

    // Expected memory image: streamed words first, FILL everywhere after.
    function automatic logic [31:0] exp_word(input int i);
        return (i < sent_q.size()) ? sent_q[i] : FILL;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap: 0 continuous valid, 1 valid dropped for one cycle between words, 2 random gaps
    task automatic stream(input int k, input bit use_last, input int gap, input bit do_start);
        bit r;
        int c, budget;
        sent_q.delete();
        xfer_q.delete();
        base = wa_q.size();
        tmo  = 1'b0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < k && !tmo; i++) begin
            if (gap == 1 && i > 0) begin
                load_valid = 1'b0;
                tick();
            end
            if (gap == 2) begin
                while ($urandom_range(0, 2) == 0) begin
                    load_valid = 1'b0;
                    tick();
                end
            end
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = use_last && (i == k - 1);
            budget = 0;
            forever begin
                @(negedge clk);
                r = load_ready;
                c = cyc;
                tick();
                if (r) break;
                budget++;
                if (budget > 50) begin
                    tmo = 1'b1;
                    break;
                end
            end
            if (!tmo) begin
                sent_q.push_back(load_data);
                xfer_q.push_back(c);
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (!tmo) begin
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!(cpu_run || overflow) && budget < 300);
            if (!(cpu_run || overflow)) tmo = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_we, mem_waddr, mem_wdata, cpu_run, busy, overflow, word_count, load_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h run=%b busy=%b ovf=%b cnt=%0d rdy=%b, want all 0",
                     mem_we, mem_waddr, mem_wdata, cpu_run, busy, overflow, word_count, load_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cpu_run, busy, load_ready, mem_we} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got run=%b busy=%b rdy=%b we=%b, want 0000", cpu_run, busy, load_ready, mem_we);
        end
    endtask

    task automatic test_short_load();
        stream(3, 1'b1, 0, 1'b1);
        checks++;
        if (tmo || wa_q.size() != base + DEPTH) begin
            errors++;
            $display("FAIL short_writes: got %0d writes (timeout=%b), want %0d", wa_q.size() - base, tmo, DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (wa_q[base+i] !== 7'(i) || wd_q[base+i] !== exp_word(i)) begin
                    errors++;
                    $display("FAIL short_write[%0d]: got addr %0d data %h, want addr %0d data %h",
                             i, wa_q[base+i], wd_q[base+i], i, exp_word(i));
                end
            end
            checks++;
            if (run_rise !== wc_q[base+DEPTH-1] + 1) begin
                errors++;
                $display("FAIL short_run_timing: cpu_run rose in cycle %0d, want %0d", run_rise, wc_q[base+DEPTH-1] + 1);
            end
            checks++;
            if (run_rise - xfer_q[0] !== DEPTH + 1) begin
                errors++;
                $display("FAIL short_total_time: got %0d cycles, want %0d", run_rise - xfer_q[0], DEPTH + 1);
            end
        end
        checks++;
        if (word_count !== 8'd3 || cpu_run !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_status: got cnt=%0d run=%b busy=%b, want cnt=3 run=1 busy=0", word_count, cpu_run, busy);
        end
    endtask

    task automatic test_full_load();
        stream(DEPTH, 1'b1, 0, 1'b1);
        checks++;
        if (tmo || wa_q.size() != base + DEPTH) begin
            errors++;
            $display("FAIL full_writes: got %0d writes (timeout=%b), want %0d", wa_q.size() - base, tmo, DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (wa_q[base+i] !== 7'(i) || wd_q[base+i] !== sent_q[i]) begin
                    errors++;
                    $display("FAIL full_write[%0d]: got addr %0d data %h, want addr %0d data %h",
                             i, wa_q[base+i], wd_q[base+i], i, sent_q[i]);
                end
            end
            checks++;
            if (run_rise !== wc_q[base+DEPTH-1] + 1) begin
                errors++;
                $display("FAIL full_run_timing: cpu_run rose in cycle %0d, want %0d", run_rise, wc_q[base+DEPTH-1] + 1);
            end
        end
        checks++;
        if (word_count !== 8'd128 || cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL full_status: got cnt=%0d run=%b, want cnt=128 run=1", word_count, cpu_run);
        end
    endtask

    task automatic test_restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (cpu_run !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_status: got run=%b rdy=%b busy=%b, want run=0 rdy=1 busy=1", cpu_run, load_ready, busy);
        end
        stream(2, 1'b1, 0, 1'b0);
        checks++;
        if (tmo || wa_q.size() != base + DEPTH) begin
            errors++;
            $display("FAIL restart_writes: got %0d writes (timeout=%b), want %0d", wa_q.size() - base, tmo, DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (wa_q[base+i] !== 7'(i) || wd_q[base+i] !== exp_word(i)) begin
                    errors++;
                    $display("FAIL restart_write[%0d]: got addr %0d data %h, want addr %0d data %h",
                             i, wa_q[base+i], wd_q[base+i], i, exp_word(i));
                end
            end
        end
        checks++;
        if (word_count !== 8'd2) begin
            errors++;
            $display("FAIL restart_count: got %0d, want 2", word_count);
        end
    endtask

    task automatic test_overflow();
        int b2;
        stream(DEPTH, 1'b0, 2, 1'b1);
        checks++;
        if (tmo || wa_q.size() != base + DEPTH) begin
            errors++;
            $display("FAIL ovf_writes: got %0d writes (timeout=%b), want %0d", wa_q.size() - base, tmo, DEPTH);
        end else begin
            checks++;
            if (wa_q[base+DEPTH-1] !== 7'd127 || wd_q[base+DEPTH-1] !== sent_q[DEPTH-1]) begin
                errors++;
                $display("FAIL ovf_last_write: got addr %0d data %h, want addr 127 data %h",
                         wa_q[base+DEPTH-1], wd_q[base+DEPTH-1], sent_q[DEPTH-1]);
            end
        end
        checks++;
        if (overflow !== 1'b1 || load_ready !== 1'b0 || cpu_run !== 1'b0 || busy !== 1'b0 || word_count !== 8'd128) begin
            errors++;
            $display("FAIL ovf_status: got ovf=%b rdy=%b run=%b busy=%b cnt=%0d, want 1 0 0 0 128",
                     overflow, load_ready, cpu_run, busy, word_count);
        end
        b2 = wa_q.size();
        load_valid = 1'b1;
        load_data  = $urandom;
        repeat (5) tick();
        load_valid = 1'b0;
        checks++;
        if (wa_q.size() != b2 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_extra_word: got %0d writes ovf=%b, want 0 writes ovf=1", wa_q.size() - b2, overflow);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || load_ready !== 1'b1 || word_count !== 8'd0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b rdy=%b cnt=%0d, want ovf=0 rdy=1 cnt=0", overflow, load_ready, word_count);
        end
        stream(4, 1'b1, 0, 1'b0);
        checks++;
        if (tmo || cpu_run !== 1'b1 || word_count !== 8'd4) begin
            errors++;
            $display("FAIL ovf_recover: got run=%b cnt=%0d timeout=%b, want run=1 cnt=4", cpu_run, word_count, tmo);
        end
    endtask

    task automatic test_gaps();
        stream(5, 1'b1, 1, 1'b1);
        checks++;
        if (tmo || wa_q.size() != base + DEPTH) begin
            errors++;
            $display("FAIL gap_writes: got %0d writes (timeout=%b), want %0d", wa_q.size() - base, tmo, DEPTH);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wa_q[base+i] !== 7'(i) || wd_q[base+i] !== sent_q[i] || wc_q[base+i] !== xfer_q[i] + 1) begin
                    errors++;
                    $display("FAIL gap_write[%0d]: got addr %0d data %h cycle %0d, want addr %0d data %h cycle %0d",
                             i, wa_q[base+i], wd_q[base+i], wc_q[base+i], i, sent_q[i], xfer_q[i] + 1);
                end
            end
            checks++;
            if (wd_q[base+5] !== FILL || wa_q[base+5] !== 7'd5) begin
                errors++;
                $display("FAIL gap_first_fill: got addr %0d data %h, want addr 5 data %h", wa_q[base+5], wd_q[base+5], FILL);
            end
        end
    endtask

    task automatic test_random_loads();
        int k;
        for (int n = 0; n < 3; n++) begin
            k = $urandom_range(1, DEPTH - 1);
            stream(k, 1'b1, 2, 1'b1);
            checks++;
            if (tmo || wa_q.size() != base + DEPTH) begin
                errors++;
                $display("FAIL rand%0d_writes: k=%0d got %0d writes (timeout=%b), want %0d", n, k, wa_q.size() - base, tmo, DEPTH);
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    checks++;
                    if (wa_q[base+i] !== 7'(i) || wd_q[base+i] !== exp_word(i)) begin
                        errors++;
                        $display("FAIL rand%0d_write[%0d]: got addr %0d data %h, want addr %0d data %h",
                                 n, i, wa_q[base+i], wd_q[base+i], i, exp_word(i));
                    end
                end
                checks++;
                if (run_rise !== wc_q[base+DEPTH-1] + 1) begin
                    errors++;
                    $display("FAIL rand%0d_run_timing: got %0d, want %0d", n, run_rise, wc_q[base+DEPTH-1] + 1);
                end
            end
            checks++;
            if (word_count !== 8'(k)) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d, want %0d", n, word_count, k);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int budget = 0;
        int b2;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        load_last  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(mem_we && mem_waddr == 7'd40) && budget < 200);
        checks++;
        if (!(mem_we && mem_waddr == 7'd40)) begin
            errors++;
            $display("FAIL midfill_reach40: got we=%b addr=%0d, want we=1 addr=40", mem_we, mem_waddr);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_waddr, mem_wdata, cpu_run, busy, overflow, word_count, load_ready} !== '0) begin
            errors++;
            $display("FAIL midfill_reset: got we=%b addr=%0d data=%h run=%b busy=%b ovf=%b cnt=%0d rdy=%b, want all 0",
                     mem_we, mem_waddr, mem_wdata, cpu_run, busy, overflow, word_count, load_ready);
        end
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        b2 = wa_q.size();
        repeat (6) tick();
        checks++;
        if (wa_q.size() != b2 || busy !== 1'b0 || load_ready !== 1'b0 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL midfill_idle: got writes=%0d busy=%b rdy=%b run=%b, want 0 0 0 0",
                     wa_q.size() - b2, busy, load_ready, cpu_run);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_short_load();
        test_full_load();
        test_restart();
        test_overflow();
        test_gaps();
        test_random_loads();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
